// File: rtl/sram_controller.sv
// Bridge from the MEM stage to a narrow SRAM. Each CPU word is split into
// SRAM-width beats, least-significant first, with WAIT_CYCLES extra cycles per beat.
module sram_controller #(
    parameter int CPU_DATA_W  = 32,
    parameter int CPU_ADDR_W  = 32,
    parameter int SRAM_DATA_W = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1,
    parameter logic [CPU_ADDR_W-1:0] BASE_ADDR = CPU_ADDR_W'(32'd1024)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [CPU_ADDR_W-1:0]  address,
    input  logic [CPU_DATA_W-1:0]  write_data,
    output logic [CPU_DATA_W-1:0]  read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);
    localparam int BEATS    = CPU_DATA_W / SRAM_DATA_W;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CYC_W    = $clog2(WAIT_CYCLES + 1);
    localparam int OFF_BITS = $clog2(CPU_DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [CPU_ADDR_W-1:0]   word_q, word_d;
    logic [CPU_DATA_W-1:0]   wdata_q, wdata_d;
    logic [CPU_DATA_W-1:0]   asm_q, asm_d;
    logic [CPU_DATA_W-1:0]   read_data_q, read_data_d;
    logic                    op_wr_q, op_wr_d;
    logic [SRAM_ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic                    we_n_q, we_n_d;

    logic                    req_s;
    logic                    beat_end_s;
    logic                    last_beat_s;
    logic [CPU_ADDR_W-1:0]   req_word_s;
    logic [SRAM_DATA_W-1:0]  dq_out_s;

    // SRAM word address of a given beat; wraps to the SRAM address width.
    function automatic logic [SRAM_ADDR_W-1:0] beat_addr(
        input logic [CPU_ADDR_W-1:0] word,
        input logic [BEAT_W-1:0]     beat
    );
        logic [CPU_ADDR_W-1:0] full;
        full = word * CPU_ADDR_W'(BEATS) + CPU_ADDR_W'(beat);
        return full[SRAM_ADDR_W-1:0];
    endfunction

    assign req_s       = wr_en | rd_en;
    assign req_word_s  = (address - BASE_ADDR) >> OFF_BITS;
    assign beat_end_s  = (cyc_q == CYC_W'(WAIT_CYCLES));
    assign last_beat_s = (beat_q == BEAT_W'(BEATS - 1));
    assign dq_out_s    = wdata_q[beat_q * SRAM_DATA_W +: SRAM_DATA_W];

    // Next-state and datapath decode for the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cyc_d       = cyc_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        asm_d       = asm_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d     = ACCESS;
                    beat_d      = '0;
                    cyc_d       = '0;
                    word_d      = req_word_s;
                    wdata_d     = write_data;
                    op_wr_d     = wr_en;
                    sram_addr_d = beat_addr(req_word_s, BEAT_W'(1'b0));
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!beat_end_s) begin
                    cyc_d = cyc_q + CYC_W'(1'b1);
                end else begin
                    cyc_d = '0;
                    // Shift in from the top so beat 0 ends up in the low slice.
                    if (!op_wr_q) begin
                        asm_d = (asm_q >> SRAM_DATA_W)
                              | (CPU_DATA_W'(SRAM_DQ) << (CPU_DATA_W - SRAM_DATA_W));
                    end else begin
                        asm_d = asm_q;
                    end
                    if (last_beat_s) begin
                        state_d = DONE;
                        if (!op_wr_q) begin
                            read_data_d = asm_d;
                        end else begin
                            read_data_d = read_data_q;
                        end
                    end else begin
                        beat_d      = beat_q + BEAT_W'(1'b1);
                        sram_addr_d = beat_addr(word_q, beat_q + BEAT_W'(1'b1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        we_n_d = !((state_d == ACCESS) && op_wr_d);
    end

    // State, latched request and registered SRAM controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cyc_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            op_wr_q     <= 1'b0;
            asm_q       <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cyc_q       <= cyc_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            op_wr_q     <= op_wr_d;
            asm_q       <= asm_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
        end
    end

    assign SRAM_DQ   = we_n_q ? {SRAM_DATA_W{1'bz}} : dq_out_s;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_ADDR = sram_addr_q;
    assign read_data = read_data_q;
    assign ready     = !(req_s && (state_q != DONE));

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default instance plus a WAIT_CYCLES=3 instance,
// each attached to a small 16-bit SRAM model that returns data one cycle after the address.
module tb_sram_controller;
    logic        clk;
    logic        rst;
    logic        mem_clr;
    logic        probe;

    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    wire  [15:0] sram_dq;

    logic        rd_en2;
    logic [31:0] address2, read_data2;
    logic        ready2;
    logic [17:0] sram_addr2;
    logic        sram_we_n2;
    wire  [15:0] sram_dq2;
    logic        wr_zero;
    logic [31:0] wdata_zero;

    logic [15:0] mem1 [0:63];
    logic [15:0] mem2 [0:63];
    logic [5:0]  rd_addr1, rd_addr2;

    int checks;
    int errors;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_we_low;
        int          mem_idx;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [6];

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_DQ(sram_dq)
    );

    sram_controller #(.WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_zero), .rd_en(rd_en2),
        .address(address2), .write_data(wdata_zero), .read_data(read_data2),
        .ready(ready2), .SRAM_ADDR(sram_addr2), .SRAM_WE_N(sram_we_n2), .SRAM_DQ(sram_dq2)
    );

    always #5 clk = ~clk;

    // SRAM models: write while WE_N low, read data appears one cycle after the address.
    always @(posedge clk) begin
        rd_addr1 <= sram_addr[5:0];
        rd_addr2 <= sram_addr2[5:0];
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 16'h0000;
                mem2[i] <= 16'h0000;
            end
            mem2[0] <= 16'hBEEF;
            mem2[1] <= 16'hDEAD;
        end else begin
            if (!sram_we_n)  mem1[sram_addr[5:0]]  <= sram_dq;
            if (!sram_we_n2) mem2[sram_addr2[5:0]] <= sram_dq2;
        end
    end

    assign sram_dq  = !sram_we_n  ? 16'bz : (probe ? 16'hC3C3 : mem1[rd_addr1]);
    assign sram_dq2 = !sram_we_n2 ? 16'bz : mem2[rd_addr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int low;
        int we_low;
        @(negedge clk);
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        #1;
        low = 0;
        we_low = 0;
        while (!ready && low < 40) begin
            low++;
            if (!sram_we_n) we_low++;
            @(negedge clk);
        end
        chk({tag, "_ready_low"}, 32'(low), 32'd5);
        chk({tag, "_we_low"}, 32'(we_low), 32'(v.exp_we_low));
        chk({tag, "_read_data"}, read_data, v.exp_rdata);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk({tag, "_mem_lo"}, 32'(mem1[v.mem_idx]), 32'(v.exp_lo));
        chk({tag, "_mem_hi"}, 32'(mem1[v.mem_idx + 1]), 32'(v.exp_hi));
    endtask

    initial begin
        int low;
        clk = 1'b0; rst = 1'b1; mem_clr = 1'b1; probe = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        rd_en2 = 1'b0; address2 = 32'd0; wr_zero = 1'b0; wdata_zero = 32'd0;
        checks = 0; errors = 0;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 4, 0, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'h00000000, 4, 2, 16'h5678, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 32'h12345678, 0, 2, 16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'hDEADBEEF, 0, 0, 16'hBEEF, 16'hDEAD};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'hDEADBEEF, 4, 4, 16'h5A5A, 16'hA5A5};
        vecs[5] = '{1'b0, 1'b1, 32'd1030, 32'h00000000, 32'h12345678, 0, 2, 16'h5678, 16'h1234};

        repeat (2) @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_read_data", read_data, 32'd0);
        chk("idle_sram_addr", 32'(sram_addr), 32'd0);
        chk("idle_dq_released", 32'(sram_dq), 32'h0000C3C3);
        probe = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Request dropped mid-access: ready follows the live request, latched read completes.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1024;
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        chk("drop_ready_live", 32'(ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("drop_read_data", read_data, 32'hDEADBEEF);
        @(negedge clk);

        // Reset after the first write beat: second beat never reaches the SRAM.
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_mid_read_data", read_data, 32'd0);
        chk("rst_mid_mem7", 32'(mem1[7]), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        run_txn('{1'b0, 1'b1, 32'd1032, 32'h0, 32'hA5A55A5A, 0, 4, 16'h5A5A, 16'hA5A5}, "post_rst");

        // WAIT_CYCLES=3 instance: 8 ACCESS cycles, ready high in the 10th cycle.
        @(negedge clk);
        rd_en2 = 1'b1; address2 = 32'd1024;
        #1;
        low = 0;
        while (!ready2 && low < 40) begin
            low++;
            @(negedge clk);
        end
        chk("wait3_ready_low", 32'(low), 32'd9);
        chk("wait3_read_data", read_data2, 32'hDEADBEEF);
        rd_en2 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
